instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0, byte address assigned to the first encoded word after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  field set offered.
- in_ready  out  1  block accepts the field set this cycle.
- in_op  in  4  0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BLT, 5 BGE, 6 JAL, 7 JALR; 8-15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte immediate/offset.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word.
- out_instr  out  32  RV32I instruction word.
- out_addr  out  32  instruction-memory byte address of out_instr.
- out_err  out  1  word is a substituted NOP due to an encode error.
- err_cnt  out  8  saturating count of encode errors.

Function
REQ-004 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-005 Storage SHALL be a 2-entry FIFO of {instr, addr, err}; in_ready = not full; out_valid = not empty; out_* driven from the head entry, registered.
REQ-006 Latency SHALL be 1 cycle: a word accepted at edge N is visible on out_* after edge N if the FIFO was empty.
REQ-007 When full, in_ready SHALL be 0 even if out_ready is 1 (no combinational ready path); when one entry is held, simultaneous push and pop SHALL both occur and occupancy stays 1.
REQ-008 Head entry and out_* SHALL stay stable while out_valid && !out_ready.
REQ-009 Encoding, fields {funct7|imm, rs2, rs1, funct3, rd|imm, opcode}:
- ADD: 0000000, rs2, rs1, 000, rd, 0110011.
- ADDI: imm[11:0], rs1, 000, rd, 0010011.
- LW: imm[11:0], rs1, 010, rd, 0000011.
- JALR: imm[11:0], rs1, 000, rd, 1100111.
- SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
- BLT/BGE: imm[12], imm[10:5], rs2, rs1, 100/101, imm[4:1], imm[11], 1100011.
- JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
REQ-010 Unused fields per format SHALL be ignored and not affect out_instr.
REQ-011 Range checks on in_imm as signed 32-bit:
- I/S: -2048..2047.
- B: -4096..4094 and bit0 = 0.
- J: -1048576..1048574 and bit0 = 0.
- ADD: no check.
REQ-012 Illegal in_op or failed range check SHALL store instr 32'h00000013 (NOP) with err = 1; otherwise err = 0.
REQ-013 Address counter SHALL start at BASE_ADDR, increment by 4 per accepted input (including errored ones), wrap modulo 2^32; each entry stores the counter value at its acceptance.
REQ-014 err_cnt SHALL increment by 1 per accepted errored input and saturate at 255.

Reset
REQ-015 On rising edge with rstn = 0: FIFO empty, out_valid = 0, in_ready = 0 during reset then 1 on the first cycle after, address counter = BASE_ADDR, err_cnt = 0, out_instr = 0, out_addr = 0, out_err = 0.
REQ-016 Reset mid-operation SHALL discard all buffered entries, and any transfer presented on that edge SHALL be ignored.

Verification
REQ-017 ADDI rd=1, rs1=0, imm=5, out_ready=1 -> next cycle out_instr = 0x00500093, out_addr = 0x0, out_err = 0.
REQ-018 ADD rd=3, rs1=1, rs2=2, then SW rs1=1, rs2=2, imm=8 back-to-back -> 0x002081B3 at addr 0x0, then 0x0020A423 at addr 0x4.
REQ-019 JAL rd=1, imm=-4 -> 0xFFDFF0EF; BLT rs1=1, rs2=2, imm=3 -> 0x00000013, out_err = 1, err_cnt = 1.
REQ-020 out_ready=0, three ADDI offered consecutively -> first two accepted, in_ready = 0 from the third cycle; raise out_ready -> words drain in order, addrs 0x0, 0x4, then the third is accepted at addr 0x8.
REQ-021 Occupancy 1 with in_valid=1 and out_ready=1 for 10 cycles -> one word per cycle, out_valid stays 1, addresses contiguous.
REQ-022 Two entries buffered, rstn=0 for one cycle -> out_valid = 0, next accepted word gets addr BASE_ADDR, err_cnt = 0; 300 errored inputs -> err_cnt = 255.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-set encoder with a 2-entry output FIFO of {instr, addr, err}.
// Out-of-range immediates and illegal opcodes are replaced by a NOP and counted.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP   = 7'b0110011;
  localparam logic [6:0]  OPC_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;
  localparam logic [6:0]  OPC_STOR = 7'b0100011;
  localparam logic [6:0]  OPC_BR   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;
  localparam logic [6:0]  OPC_JALR = 7'b1100111;

  // Entry layout: {instr[31:0], addr[31:0], err}
  logic [64:0] head_q, head_d;
  logic [64:0] tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        ready_q;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        imm_i_ok, imm_b_ok, imm_j_ok;
  logic        push, pop;
  logic [64:0] new_entry;

  // A value fits a signed N-bit field when all bits above N-1 equal the sign bit.
  assign imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (in_op)
      4'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
      4'd1: begin
        enc_err  = ~imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_IMM};
      end
      4'd2: begin
        enc_err  = ~imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      end
      4'd3: begin
        enc_err  = ~imm_i_ok;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STOR};
      end
      4'd4, 4'd5: begin
        enc_err  = ~imm_b_ok;
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b10, in_op[0],
                    in_imm[4:1], in_imm[11], OPC_BR};
      end
      4'd6: begin
        enc_err  = ~imm_j_ok;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      4'd7: begin
        enc_err  = ~imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = NOP;
  end

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = ready_q & (count_q != 2'd2);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign new_entry = {enc_word, addr_q, enc_err};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      addr_d = addr_q + 32'd4;
      if (enc_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ready_q   <= 1'b1;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_instr = head_q[64:33];
  assign out_addr  = head_q[32:1];
  assign out_err   = head_q[0];
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_addr;
  int          m_ecnt;
  logic        m_rdy;
  logic        m_fresh;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder built directly from the field tables with integer arithmetic.
  function automatic void ref_enc(input logic [3:0] op, input logic [4:0] rd, rs1, rs2,
                                  input logic [31:0] imm, output logic [31:0] w,
                                  output logic e);
    int signed   v;
    logic [31:0] d, r1, r2, f3, opc;
    v  = imm;
    d  = {27'd0, rd};
    r1 = {27'd0, rs1};
    r2 = {27'd0, rs2};
    e  = 1'b0;
    w  = 32'h0;
    case (op)
      4'd0: w = (r2 << 20) | (r1 << 15) | (d << 7) | 32'h33;
      4'd1, 4'd2, 4'd7: begin
        f3  = (op == 4'd2) ? 32'd2 : 32'd0;
        opc = (op == 4'd1) ? 32'h13 : (op == 4'd2) ? 32'h03 : 32'h67;
        if (v < -2048 || v > 2047) e = 1'b1;
        else w = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | opc;
      end
      4'd3: begin
        if (v < -2048 || v > 2047) e = 1'b1;
        else w = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (32'd2 << 12)
                 | ((imm & 32'h1F) << 7) | 32'h23;
      end
      4'd4, 4'd5: begin
        f3 = (op == 4'd4) ? 32'd4 : 32'd5;
        if (v < -4096 || v > 4094 || imm[0]) e = 1'b1;
        else w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20)
                 | (r1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      4'd6: begin
        if (v < -1048576 || v > 1048574 || imm[0]) e = 1'b1;
        else w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                 | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                 | (d << 7) | 32'h6F;
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h13;
  endfunction

  // Check visible state against the model, take one clock edge, advance the model.
  task automatic cyc();
    ent_t        h, n;
    logic        do_push, do_pop;
    logic [31:0] w;
    logic        e;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy && mq.size() < 2});
    chk("err_cnt", {24'd0, err_cnt}, m_ecnt);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("out_instr", out_instr, h.instr);
      chk("out_addr", out_addr, h.addr);
      chk("out_err", {31'd0, out_err}, {31'd0, h.err});
    end else if (m_fresh) begin
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_addr", out_addr, 32'h0);
      chk("rst_err", {31'd0, out_err}, 32'h0);
    end
    do_push = in_valid && m_rdy && mq.size() < 2;
    do_pop  = out_ready && mq.size() != 0;
    ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm, w, e);
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      m_addr  = BASE;
      m_ecnt  = 0;
      m_rdy   = 1'b0;
      m_fresh = 1'b1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        n.instr = w;
        n.addr  = m_addr;
        n.err   = e;
        mq.push_back(n);
        m_addr  = m_addr + 32'd4;
        if (e && m_ecnt < 255) m_ecnt++;
        m_fresh = 1'b0;
      end
      m_rdy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic [3:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] imm, input logic ordy);
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_imm();
    int signed edges[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                             -1048576, -1048578, 1048574, 1048575, 1048576};
    int signed v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 10000) - 5000;
      2: v = edges[$urandom_range(0, 13)];
      default: v = $urandom_range(0, 4000000) - 2000000;
    endcase
    return v;
  endfunction

  initial begin
    rstn = 1'b0;
    put(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    m_addr = BASE; m_ecnt = 0; m_rdy = 1'b0; m_fresh = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc();
    rstn = 1'b1;
    cyc();

    // ADDI x1, x0, 5
    put(1'b1, 4'd1, 5'd1, 5'd0, 5'd9, 32'd5, 1'b1);
    cyc();
    put(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    chk("addi_word", out_instr, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    cyc();

    // ADD then SW back-to-back
    put(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1);
    cyc();
    chk("add_word", out_instr, 32'h0020_81B3);
    put(1'b1, 4'd3, 5'd31, 5'd1, 5'd2, 32'd8, 1'b1);
    cyc();
    chk("sw_word", out_instr, 32'h0020_A423);
    put(1'b1, 4'd6, 5'd1, 5'd7, 5'd7, 32'hFFFF_FFFC, 1'b1);
    cyc();
    chk("jal_word", out_instr, 32'hFFDF_F0EF);
    put(1'b1, 4'd4, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
    cyc();
    put(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    chk("blt_odd_word", out_instr, 32'h0000_0013);
    chk("blt_odd_err", {31'd0, out_err}, 32'd1);
    chk("blt_odd_cnt", {24'd0, err_cnt}, 32'd1);
    cyc();

    // Back-pressure: fill, stall, then drain in order
    put(1'b1, 4'd1, 5'd4, 5'd0, 5'd0, 32'd1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) cyc();
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) cyc();

    // Streaming at occupancy 1
    for (int unsigned i = 0; i < 10; i++) begin
      put(1'b1, 4'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
          rand_imm(), 1'b1);
      cyc();
    end

    // Reset with two entries held and a transfer presented on the reset edge
    put(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    put(1'b1, 4'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1);
    cyc();
    chk("post_rst_addr", out_addr, BASE);

    // Saturate the error counter
    put(1'b1, 4'd9, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    for (int unsigned i = 0; i < 300; i++) cyc();
    chk("err_sat", {24'd0, err_cnt}, 32'd255);

    // Random traffic
    for (int unsigned i = 0; i < 600; i++) begin
      put($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), rand_imm(), $urandom_range(0, 4) < 3);
      rstn = ($urandom_range(0, 59) != 0);
      cyc();
    end
    rstn = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
